// File: rtl/rx.sv
// rtl/rx.sv - receive side of the toggle flit channel, fills the local packet buffer
module rx #(
  parameter int ID            = 0,
  parameter int SUBID         = 0,
  parameter int SIZE          = 8,
  parameter int BUFF_BITS     = 3,
  parameter int VERBOSE_DEBUG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ch_req,
  input  logic [SIZE-1:0]      ch_flit,
  output logic                 ch_ack,
  output logic                 buf_wr,
  output logic [BUFF_BITS-1:0] buf_addr,
  output logic [SIZE-1:0]      buf_data,
  output logic                 pkt_req,
  input  logic                 pkt_done
);

  // Address of the final flit of a packet; reaching it hands the buffer to the switch.
  localparam logic [BUFF_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_RECEIVING      = 2'd0,
    ST_HOLD           = 2'd1,
    ST_WAIT_DONE_DOWN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ch_ack;
  logic                 w_ch_ack_nxt;
  logic                 r_buf_wr;
  logic                 w_buf_wr_nxt;
  logic [BUFF_BITS-1:0] r_buf_addr;
  logic [BUFF_BITS-1:0] w_buf_addr_nxt;
  logic [SIZE-1:0]      r_buf_data;
  logic [SIZE-1:0]      w_buf_data_nxt;
  logic                 r_pkt_req;
  logic                 w_pkt_req_nxt;
  logic [BUFF_BITS-1:0] r_flit_counter;
  logic [BUFF_BITS-1:0] w_flit_counter_nxt;
  logic                 w_pending;

  // The identifiers only tag debug traces, so reject nonsensical values at elaboration.
  if (SIZE < 1 || BUFF_BITS < 1 || ID < 0 || SUBID < 0 ||
      (VERBOSE_DEBUG != 0 && VERBOSE_DEBUG != 1)) begin : g_bad_params
    $error("rx: illegal parameter set");
  end

  // Level-based pending: a toggle that arrives while blocked stays visible until acked.
  assign w_pending = ch_req ^ r_ch_ack;

  assign ch_ack   = r_ch_ack;
  assign buf_wr   = r_buf_wr;
  assign buf_addr = r_buf_addr;
  assign buf_data = r_buf_data;
  assign pkt_req  = r_pkt_req;

  // State and registered outputs; reset discards any partial packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RECEIVING;
      r_ch_ack       <= 1'b0;
      r_buf_wr       <= 1'b0;
      r_buf_addr     <= '0;
      r_buf_data     <= '0;
      r_pkt_req      <= 1'b0;
      r_flit_counter <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ch_ack       <= w_ch_ack_nxt;
      r_buf_wr       <= w_buf_wr_nxt;
      r_buf_addr     <= w_buf_addr_nxt;
      r_buf_data     <= w_buf_data_nxt;
      r_pkt_req      <= w_pkt_req_nxt;
      r_flit_counter <= w_flit_counter_nxt;
    end
  end

  // Next-state logic: accept flits while receiving, block from packet-full until pkt_done falls.
  always_comb begin
    w_state_nxt        = r_state;
    w_ch_ack_nxt       = r_ch_ack;
    w_buf_wr_nxt       = 1'b0;
    w_buf_addr_nxt     = r_buf_addr;
    w_buf_data_nxt     = r_buf_data;
    w_pkt_req_nxt      = r_pkt_req;
    w_flit_counter_nxt = r_flit_counter;

    case (r_state)
      ST_RECEIVING: begin
        if (w_pending) begin
          w_ch_ack_nxt       = ~r_ch_ack;
          w_buf_wr_nxt       = 1'b1;
          w_buf_addr_nxt     = r_flit_counter;
          w_buf_data_nxt     = ch_flit;
          w_flit_counter_nxt = r_flit_counter + 1'b1;
          // The counter wraps to zero here, so the next packet starts at address 0.
          if (r_flit_counter == LAST_ADDR) begin
            w_state_nxt   = ST_HOLD;
            w_pkt_req_nxt = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (pkt_done) begin
          w_pkt_req_nxt = 1'b0;
          w_state_nxt   = ST_WAIT_DONE_DOWN;
        end
      end
      ST_WAIT_DONE_DOWN: begin
        if (!pkt_done) begin
          w_state_nxt = ST_RECEIVING;
        end
      end
      default: begin
        w_state_nxt = ST_RECEIVING;
      end
    endcase
  end

endmodule

// File: tb/tb_rx.sv
// tb/tb_rx.sv - randomized self-checking bench for rx against a packet-level model
module tb_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ch_req;
  logic [7:0] ch_flit;
  logic       ch_ack;
  logic       buf_wr;
  logic [2:0] buf_addr;
  logic [7:0] buf_data;
  logic       pkt_req;
  logic       pkt_done;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Observed buffer writes, captured shortly after each rising edge.
  logic [2:0] mq_addr[$];
  logic [7:0] mq_data[$];
  logic       mq_pkt[$];
  int         mq_cyc[$];

  rx #(.ID(0), .SUBID(0), .SIZE(8), .BUFF_BITS(3), .VERBOSE_DEBUG(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_req   (ch_req),
    .ch_flit  (ch_flit),
    .ch_ack   (ch_ack),
    .buf_wr   (buf_wr),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .pkt_req  (pkt_req),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (buf_wr === 1'b1) begin
      mq_addr.push_back(buf_addr);
      mq_data.push_back(buf_data);
      mq_pkt.push_back(pkt_req);
      mq_cyc.push_back(cyc);
    end
  end

  task automatic clear_mon();
    mq_addr.delete();
    mq_data.delete();
    mq_pkt.delete();
    mq_cyc.delete();
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ch_ack !== ch_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ch_ack !== ch_req) begin
      vectors++;
      errors++;
      $display("FAIL ack_timeout: ch_ack=%b still differs from ch_req=%b", ch_ack, ch_req);
    end
  endtask

  task automatic send_flit(input logic [7:0] d);
    wait_ack();
    ch_flit = d;
    ch_req  = ~ch_req;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    ch_req   = 1'b0;
    pkt_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    ch_req   = 1'b1;
    ch_flit  = 8'h5A;
    pkt_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vectors += 5;
    if (ch_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ch_ack); end
    if (buf_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b expected 0", buf_wr); end
    if (pkt_req !== 1'b0) begin errors++; $display("FAIL reset_pkt_req: got %b expected 0", pkt_req); end
    if (buf_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", buf_addr); end
    if (buf_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", buf_data); end
    @(negedge clk);
    vectors += 4;
    if (ch_ack !== 1'b1) begin errors++; $display("FAIL first_ack: got %b expected 1", ch_ack); end
    if (buf_wr !== 1'b1) begin errors++; $display("FAIL first_wr: got %b expected 1", buf_wr); end
    if (buf_addr !== 3'd0) begin errors++; $display("FAIL first_addr: got %0d expected 0", buf_addr); end
    if (buf_data !== 8'h5A) begin errors++; $display("FAIL first_data: got %h expected 5a", buf_data); end
    @(negedge clk);
    vectors++;
    if (buf_wr !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: got %b expected 0", buf_wr); end
    do_reset();
  endtask

  task automatic test_full_packet();
    logic [7:0] d;
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      d = 8'hA0 + 8'(i);
      send_flit(d);
    end
    wait_ack();
    vectors += 3;
    if (mq_addr.size() != 8) begin errors++; $display("FAIL full_count: got %0d expected 8", mq_addr.size()); end
    if (pkt_req !== 1'b1) begin errors++; $display("FAIL full_pkt_req: got %b expected 1", pkt_req); end
    if (ch_ack !== ch_req) begin errors++; $display("FAIL full_final_ack: got %b expected %b", ch_ack, ch_req); end
    for (int i = 0; i < 8 && i < mq_addr.size(); i++) begin
      vectors += 3;
      if (mq_addr[i] !== 3'(i)) begin errors++; $display("FAIL full_addr[%0d]: got %0d expected %0d", i, mq_addr[i], i); end
      if (mq_data[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, mq_data[i], 8'hA0 + 8'(i)); end
      if (mq_pkt[i] !== (i == 7)) begin errors++; $display("FAIL full_pkt_at[%0d]: got %b expected %b", i, mq_pkt[i], (i == 7)); end
      if (i > 0) begin
        vectors++;
        if (mq_cyc[i] - mq_cyc[i-1] != 1) begin errors++; $display("FAIL back_to_back[%0d]: gap %0d expected 1", i, mq_cyc[i] - mq_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic a0;
    clear_mon();
    a0      = ch_ack;
    ch_flit = 8'hB0;
    ch_req  = ~ch_req;
    repeat (10) @(negedge clk);
    vectors += 3;
    if (mq_addr.size() != 0) begin errors++; $display("FAIL hold_writes: got %0d expected 0", mq_addr.size()); end
    if (ch_ack !== a0) begin errors++; $display("FAIL hold_ack: got %b expected %b", ch_ack, a0); end
    if (pkt_req !== 1'b1) begin errors++; $display("FAIL hold_pkt_req: got %b expected 1", pkt_req); end
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    vectors += 2;
    if (pkt_req !== 1'b0) begin errors++; $display("FAIL done_pkt_req: got %b expected 0", pkt_req); end
    if (mq_addr.size() != 0) begin errors++; $display("FAIL done_writes: got %0d expected 0", mq_addr.size()); end
    @(negedge clk);
    vectors += 2;
    if (mq_addr.size() != 0) begin errors++; $display("FAIL wait_down_writes: got %0d expected 0", mq_addr.size()); end
    if (ch_ack !== a0) begin errors++; $display("FAIL wait_down_ack: got %b expected %b", ch_ack, a0); end
    @(negedge clk);
    vectors += 2;
    if (mq_addr.size() != 1) begin
      errors++; $display("FAIL resume_writes: got %0d expected 1", mq_addr.size());
    end else begin
      vectors += 2;
      if (mq_addr[0] !== 3'd0) begin errors++; $display("FAIL resume_addr: got %0d expected 0", mq_addr[0]); end
      if (mq_data[0] !== 8'hB0) begin errors++; $display("FAIL resume_data: got %h expected b0", mq_data[0]); end
    end
    if (ch_ack === a0) begin errors++; $display("FAIL resume_ack: got %b expected %b", ch_ack, ~a0); end
  endtask

  task automatic test_done_held();
    logic a0;
    clear_mon();
    for (int i = 1; i < 8; i++) send_flit(8'hE0 + 8'(i));
    wait_ack();
    vectors += 2;
    if (pkt_req !== 1'b1) begin errors++; $display("FAIL held_fill_pkt_req: got %b expected 1", pkt_req); end
    if (mq_addr.size() != 7 || mq_addr[mq_addr.size()-1] !== 3'd7) begin
      errors++; $display("FAIL held_fill: got %0d writes expected 7 ending at addr 7", mq_addr.size());
    end
    clear_mon();
    a0       = ch_ack;
    ch_flit  = 8'hD0;
    ch_req   = ~ch_req;
    pkt_done = 1'b1;
    repeat (5) @(negedge clk);
    vectors += 3;
    if (pkt_req !== 1'b0) begin errors++; $display("FAIL held_pkt_req: got %b expected 0", pkt_req); end
    if (mq_addr.size() != 0) begin errors++; $display("FAIL held_writes: got %0d expected 0", mq_addr.size()); end
    if (ch_ack !== a0) begin errors++; $display("FAIL held_ack: got %b expected %b", ch_ack, a0); end
    pkt_done = 1'b0;
    @(negedge clk);
    vectors++;
    if (mq_addr.size() != 0) begin errors++; $display("FAIL held_fall_writes: got %0d expected 0", mq_addr.size()); end
    @(negedge clk);
    vectors++;
    if (mq_addr.size() != 1 || mq_addr[0] !== 3'd0 || mq_data[0] !== 8'hD0) begin
      errors++; $display("FAIL held_resume: got %0d writes expected one of d0 at addr 0", mq_addr.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    clear_mon();
    for (int i = 0; i < 3; i++) send_flit(8'($urandom_range(255, 0)));
    wait_ack();
    vectors++;
    if (mq_addr.size() != 3 || mq_addr[2] !== 3'd2) begin
      errors++; $display("FAIL partial_writes: got %0d writes expected 3 ending at addr 2", mq_addr.size());
    end
    @(negedge clk);
    reset  = 1'b1;
    ch_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    vectors += 2;
    if (ch_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", ch_ack); end
    if (pkt_req !== 1'b0) begin errors++; $display("FAIL midrst_pkt_req: got %b expected 0", pkt_req); end
    clear_mon();
    for (int i = 0; i < 8; i++) send_flit(8'hC0 + 8'(i));
    wait_ack();
    vectors++;
    if (mq_addr.size() != 8) begin errors++; $display("FAIL midrst_count: got %0d expected 8", mq_addr.size()); end
    for (int i = 0; i < 8 && i < mq_addr.size(); i++) begin
      vectors += 3;
      if (mq_addr[i] !== 3'(i)) begin errors++; $display("FAIL midrst_addr[%0d]: got %0d expected %0d", i, mq_addr[i], i); end
      if (mq_data[i] !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, mq_data[i], 8'hC0 + 8'(i)); end
      if (mq_pkt[i] !== (i == 7)) begin errors++; $display("FAIL midrst_pkt_at[%0d]: got %b expected %b", i, mq_pkt[i], (i == 7)); end
    end
    pkt_done = 1'b1;
    @(negedge clk);
    pkt_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       a0;
    int         in_pkt = 0;
    clear_mon();
    for (int p = 0; p < 5; p++) begin
      while (in_pkt < 8) begin
        repeat ($urandom_range(3, 0)) @(negedge clk);
        d = 8'($urandom_range(255, 0));
        send_flit(d);
        exp_q.push_back(d);
        in_pkt++;
      end
      wait_ack();
      vectors++;
      if (pkt_req !== 1'b1) begin errors++; $display("FAIL rand_pkt_req[%0d]: got %b expected 1", p, pkt_req); end
      in_pkt = 0;
      a0 = ch_ack;
      if ($urandom_range(1, 0) == 1) begin
        d       = 8'($urandom_range(255, 0));
        ch_flit = d;
        ch_req  = ~ch_req;
        exp_q.push_back(d);
        in_pkt  = 1;
      end
      repeat ($urandom_range(6, 1)) @(negedge clk);
      vectors++;
      if (ch_ack !== a0) begin errors++; $display("FAIL rand_hold_ack[%0d]: got %b expected %b", p, ch_ack, a0); end
      pkt_done = 1'b1;
      repeat ($urandom_range(4, 1)) @(negedge clk);
      pkt_done = 1'b0;
    end
    wait_ack();
    repeat (2) @(negedge clk);
    vectors++;
    if (mq_addr.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", mq_addr.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mq_addr.size(); i++) begin
      vectors += 2;
      if (mq_addr[i] !== 3'(i % 8)) begin errors++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, mq_addr[i], i % 8); end
      if (mq_data[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, mq_data[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    ch_req   = 1'b0;
    ch_flit  = 8'h00;
    pkt_done = 1'b0;
    test_reset();
    test_full_packet();
    test_backpressure();
    test_done_held();
    test_reset_mid_packet();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
